// File: rtl/mac_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mac_pkg
// Description : Shared widths and helpers for the multiply-accumulate path.
// Revision    : 1.0  initial release
// ============================================================================
package mac_pkg;

    localparam int c_PROD_W = 16;
    localparam int c_ACC_W  = 24;
    localparam int c_CNT_W  = 8;

    // Increment that sticks at the all-ones value of a width-bit counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                            input int unsigned width);
        logic [32:0] max_val;
        max_val = (33'd1 << width) - 33'd1;
        if ({1'b0, val} >= max_val) begin
            return val;
        end
        return val + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/product_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : product_accumulator
// Description : Sums framed product beats; one registered result per frame.
// Revision    : 1.0  initial release
// ============================================================================
module product_accumulator
    import mac_pkg::*;
#(
    parameter int PROD_W = c_PROD_W,
    parameter int ACC_W  = c_ACC_W,
    parameter int CNT_W  = c_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_product,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_overflow,
    output logic              busy
);

    localparam logic [0:0] c_ACCUM = 1'b0;
    localparam logic [0:0] c_HOLD  = 1'b1;

    logic [0:0]       r_state;
    logic [0:0]       w_state_next;
    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf_acc;
    logic             r_busy;
    logic [ACC_W-1:0] r_out_sum;
    logic [CNT_W-1:0] r_out_count;
    logic             r_out_overflow;

    logic [ACC_W:0]   w_sum;
    logic             w_carry;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_last_accept;

    assign w_in_ready    = (r_state == c_ACCUM) || out_ready;
    assign w_accept      = in_valid && w_in_ready;
    assign w_last_accept = w_accept && in_last;

    // One extra bit on the adder exposes the carry out of the accumulator.
    assign w_sum     = {1'b0, r_acc} + (ACC_W+1)'(in_product);
    assign w_carry   = w_sum[ACC_W];
    assign w_cnt_inc = CNT_W'(sat_inc(32'(r_cnt), CNT_W));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc     <= '0;
            r_cnt     <= '0;
            r_ovf_acc <= 1'b0;
            r_busy    <= 1'b0;
        end else if (w_accept) begin
            if (in_last) begin
                r_acc     <= '0;
                r_cnt     <= '0;
                r_ovf_acc <= 1'b0;
                r_busy    <= 1'b0;
            end else begin
                r_acc     <= w_sum[ACC_W-1:0];
                r_cnt     <= w_cnt_inc;
                r_ovf_acc <= r_ovf_acc | w_carry;
                r_busy    <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ACCUM: if (w_last_accept) w_state_next = c_HOLD;
            c_HOLD:  if (out_ready && !w_last_accept) w_state_next = c_ACCUM;
            default: w_state_next = c_ACCUM;
        endcase
    end

    // A last beat arriving while the held result drains replaces it directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= c_ACCUM;
            r_out_sum      <= '0;
            r_out_count    <= '0;
            r_out_overflow <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_last_accept) begin
                r_out_sum      <= w_sum[ACC_W-1:0];
                r_out_count    <= w_cnt_inc;
                r_out_overflow <= r_ovf_acc | w_carry;
            end
        end
    end

    assign in_ready     = w_in_ready;
    assign out_valid    = (r_state == c_HOLD);
    assign out_sum      = r_out_sum;
    assign out_count    = r_out_count;
    assign out_overflow = r_out_overflow;
    assign busy         = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_product_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_product_accumulator
// Description : Directed and randomized bench for two accumulator widths.
// Revision    : 1.0  initial release
// ============================================================================
module tb_product_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_last;
    logic        out_ready;
    logic [15:0] in_product;

    logic        a_in_ready, a_out_valid, a_ovf, a_busy;
    logic [23:0] a_sum;
    logic [7:0]  a_cnt;
    logic        b_in_ready, b_out_valid, b_ovf, b_busy;
    logic [16:0] b_sum;
    logic [7:0]  b_cnt;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    always #5 clk = ~clk;

    product_accumulator #(.PROD_W(16), .ACC_W(24), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_product(in_product), .in_last(in_last), .out_valid(a_out_valid),
        .out_ready(out_ready), .out_sum(a_sum), .out_count(a_cnt),
        .out_overflow(a_ovf), .busy(a_busy)
    );

    product_accumulator #(.PROD_W(16), .ACC_W(17), .CNT_W(8)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_product(in_product), .in_last(in_last), .out_valid(b_out_valid),
        .out_ready(out_ready), .out_sum(b_sum), .out_count(b_cnt),
        .out_overflow(b_ovf), .busy(b_busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] wrap(input longint s, input int w);
        return 64'(s) & ((64'd1 << w) - 64'd1);
    endfunction

    // Reference: exact frame sum and beat count; widths applied only when compared.
    longint m_s, m_res_s;
    int     m_n, m_res_n;
    bit     m_valid, m_acc;

    always @(posedge clk) begin
        if (rst) begin
            m_s = 0; m_n = 0; m_valid = 0; m_res_s = 0; m_res_n = 0;
        end else begin
            m_acc = in_valid && (!m_valid || out_ready);
            if (m_valid && out_ready) m_valid = 0;
            if (m_acc) begin
                m_s += longint'(in_product);
                m_n++;
                if (in_last) begin
                    m_valid = 1; m_res_s = m_s; m_res_n = m_n;
                    m_s = 0; m_n = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en && !rst) begin
            chk("a_in_ready", 64'(a_in_ready), 64'(!m_valid || out_ready));
            chk("b_in_ready", 64'(b_in_ready), 64'(!m_valid || out_ready));
            chk("a_out_valid", 64'(a_out_valid), 64'(m_valid));
            chk("b_out_valid", 64'(b_out_valid), 64'(m_valid));
            chk("a_busy", 64'(a_busy), 64'(m_n > 0));
            chk("b_busy", 64'(b_busy), 64'(m_n > 0));
            if (m_valid) begin
                chk("a_sum", 64'(a_sum), wrap(m_res_s, 24));
                chk("b_sum", 64'(b_sum), wrap(m_res_s, 17));
                chk("a_count", 64'(a_cnt), 64'((m_res_n > 255) ? 255 : m_res_n));
                chk("b_count", 64'(b_cnt), 64'((m_res_n > 255) ? 255 : m_res_n));
                chk("a_overflow", 64'(a_ovf), 64'(m_res_s >= (64'sd1 <<< 24)));
                chk("b_overflow", 64'(b_ovf), 64'(m_res_s >= (64'sd1 <<< 17)));
            end
        end
    end

    // Holds a beat on the inputs until the edge that accepts it.
    task automatic beat(input logic [15:0] p, input logic l);
        bit rd;
        int guard;
        guard = 0;
        in_valid = 1'b1; in_product = p; in_last = l;
        do begin
            @(negedge clk); rd = a_in_ready;
            @(posedge clk); #1;
            guard++;
        end while (!rd && guard < 1000);
        if (!rd) begin
            n_checks++; n_errors++;
            $display("FAIL beat_timeout: got in_ready=0 expected 1 within 1000 cycles");
        end
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_product = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_valid", 64'(a_out_valid), 64'd0);
        chk("reset_ready", 64'(a_in_ready), 64'd1);
        chk("reset_busy", 64'(a_busy), 64'd0);
        chk("reset_sum", 64'(a_sum), 64'd0);
        chk("reset_count", 64'(a_cnt), 64'd0);
        cmp_en = 1'b1;
        @(posedge clk); #1;

        // Basic frame, one-cycle result
        beat(16'd50, 1'b0); beat(16'd24, 1'b0); beat(16'd105, 1'b1);
        @(negedge clk);
        chk("t1_valid", 64'(a_out_valid), 64'd1);
        chk("t1_sum", 64'(a_sum), 64'd179);
        chk("t1_count", 64'(a_cnt), 64'd3);
        chk("t1_ovf", 64'(a_ovf), 64'd0);
        @(negedge clk);
        chk("t1_valid_drop", 64'(a_out_valid), 64'd0);
        @(posedge clk); #1;

        // Zero single-beat frames
        beat(16'd0, 1'b1);
        @(negedge clk);
        chk("t2a_sum", 64'(a_sum), 64'd0);
        chk("t2a_count", 64'(a_cnt), 64'd1);
        @(posedge clk); #1;
        beat(16'd0, 1'b1);
        @(negedge clk);
        chk("t2b_sum", 64'(a_sum), 64'd0);
        chk("t2b_count", 64'(a_cnt), 64'd1);
        @(posedge clk); #1;

        // Backpressure
        out_ready = 1'b0;
        beat(16'd15, 1'b0); beat(16'd60, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_hold_valid", 64'(a_out_valid), 64'd1);
            chk("t3_hold_ready", 64'(a_in_ready), 64'd0);
            chk("t3_hold_sum", 64'(a_sum), 64'd75);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        chk("t3_release_ready", 64'(a_in_ready), 64'd1);
        @(negedge clk);
        chk("t3_after_valid", 64'(a_out_valid), 64'd0);
        chk("t3_after_ready", 64'(a_in_ready), 64'd1);
        @(posedge clk); #1;

        // Narrow accumulator overflow
        beat(16'd65025, 1'b0); beat(16'd65025, 1'b0); beat(16'd65025, 1'b1);
        @(negedge clk);
        chk("t4_b_sum", 64'(b_sum), 64'd64003);
        chk("t4_b_ovf", 64'(b_ovf), 64'd1);
        chk("t4_a_sum", 64'(a_sum), 64'd195075);
        chk("t4_a_ovf", 64'(a_ovf), 64'd0);
        @(posedge clk); #1;
        beat(16'd1, 1'b1);
        @(negedge clk);
        chk("t4_next_sum", 64'(b_sum), 64'd1);
        chk("t4_next_ovf", 64'(b_ovf), 64'd0);
        @(posedge clk); #1;

        // Reset mid-frame discards the partial sum
        beat(16'd100, 1'b0); beat(16'd200, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("t5_busy", 64'(a_busy), 64'd0);
        chk("t5_valid", 64'(a_out_valid), 64'd0);
        chk("t5_sum", 64'(a_sum), 64'd0);
        chk("t5_count", 64'(a_cnt), 64'd0);
        chk("t5_ovf", 64'(b_ovf), 64'd0);
        @(posedge clk); #1;
        beat(16'd7, 1'b1);
        @(negedge clk);
        chk("t5_sum7", 64'(a_sum), 64'd7);
        chk("t5_count1", 64'(a_cnt), 64'd1);
        @(posedge clk); #1;

        // Result drained and replaced on the same edge
        beat(16'd5, 1'b1); beat(16'd9, 1'b1);
        @(negedge clk);
        chk("t6_valid", 64'(a_out_valid), 64'd1);
        chk("t6_sum", 64'(a_sum), 64'd9);
        @(negedge clk);
        chk("t6_drop", 64'(a_out_valid), 64'd0);
        @(posedge clk); #1;

        // Counter saturation and wide overflow
        for (int i = 0; i < 299; i++) beat(16'hFFFF, 1'b0);
        beat(16'hFFFF, 1'b1);
        @(negedge clk);
        chk("sat_count", 64'(a_cnt), 64'd255);
        chk("sat_sum", 64'(a_sum), 64'd2883284);
        chk("sat_ovf", 64'(a_ovf), 64'd1);
        @(posedge clk); #1;

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            in_product = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            in_last    = ($urandom_range(0, 5) == 0);
            out_ready  = ($urandom_range(0, 3) != 0);
            rst        = ($urandom_range(0, 199) == 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; in_last = 1'b0; rst = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
